// File: rtl/inert_pkg.sv
// Shared state encoding and SPI command tables for the inertial sensor read sequencer.
package inert_pkg;

  typedef enum logic [1:0] {
    PWR_WAIT = 2'd0,
    CFG_WR   = 2'd1,
    WAIT_INT = 2'd2,
    RD       = 2'd3
  } state_t;

  localparam int NUM_CFG_DEF = 4;

  // Config writes: register address in [15:8], value in [7:0].
  localparam logic [15:0] CFG_CMD [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

  // Reads: pitch-rate L/H then AZ L/H; low byte is don't-care and sent as zero.
  localparam logic [15:0] RD_CMD  [0:3] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

endpackage

// File: rtl/inert_rd_seq.sv
// Inertial sensor command sequencer: power-up wait, config writes, then 4-byte reads per INT.
// Optional INT synchronizer is enabled by defining INERT_INT_SYNC_EN.
module inert_rd_seq
  import inert_pkg::*;
#(
  parameter int PWR_W   = 16,
  parameter int NUM_CFG = NUM_CFG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        cfg_done,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output state_t      dbg_state
);

  // Handshake: wrt pulses for one cycle with cmd valid; the SPI master owns the
  // transaction until done rises again, and cmd is held unchanged until then.
  // Only the rising edge of done (cmplt) advances the sequence.

  state_t           state;
  logic [PWR_W-1:0] timer;
  logic [1:0]       idx;
  logic             done_q;
  logic             cmplt;
  logic             int_s;
  logic [7:0]       pitch_l;
  logic [7:0]       pitch_h;
  logic [7:0]       az_l;
  logic             unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign cmplt        = done & ~done_q;
  assign dbg_state    = state;

`ifdef INERT_INT_SYNC_EN
  logic int_ff1;
  logic int_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
    end
  end

  assign int_s = int_ff2;
`else
  assign int_s = INT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWR_WAIT;
      timer    <= '0;
      idx      <= 2'd0;
      done_q   <= 1'b1;
      wrt      <= 1'b0;
      cmd      <= 16'h0000;
      cfg_done <= 1'b0;
      ptch_rt  <= 16'h0000;
      AZ       <= 16'h0000;
      vld      <= 1'b0;
      pitch_l  <= 8'h00;
      pitch_h  <= 8'h00;
      az_l     <= 8'h00;
    end else begin
      done_q <= done;
      wrt    <= 1'b0;
      vld    <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (&timer) begin
            state <= CFG_WR;
            idx   <= 2'd0;
            wrt   <= 1'b1;
            cmd   <= CFG_CMD[0];
          end else begin
            timer <= timer + PWR_W'(1);
          end
        end
        CFG_WR: begin
          if (cmplt) begin
            if (int'(idx) < NUM_CFG - 1) begin
              idx <= idx + 2'd1;
              wrt <= 1'b1;
              cmd <= CFG_CMD[idx + 2'd1];
            end else begin
              cfg_done <= 1'b1;
              idx      <= 2'd0;
              state    <= WAIT_INT;
            end
          end
        end
        WAIT_INT: begin
          if (int_s) begin
            state <= RD;
            idx   <= 2'd0;
            wrt   <= 1'b1;
            cmd   <= RD_CMD[0];
          end
        end
        RD: begin
          if (cmplt) begin
            case (idx)
              2'd0:    pitch_l <= rd_data[7:0];
              2'd1:    pitch_h <= rd_data[7:0];
              2'd2:    az_l    <= rd_data[7:0];
              default: ;
            endcase
            // Last byte bypasses the byte regs so the pair lands one cycle after cmplt.
            if (idx == 2'd3) begin
              ptch_rt <= {pitch_h, pitch_l};
              AZ      <= {rd_data[7:0], az_l};
              vld     <= 1'b1;
              idx     <= 2'd0;
              state   <= WAIT_INT;
            end else begin
              idx <= idx + 2'd1;
              wrt <= 1'b1;
              cmd <= RD_CMD[idx + 2'd1];
            end
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_rd_seq.sv
// Self-checking bench for inert_rd_seq: SPI master model, expected command/pair queues, monitor.
module tb_inert_rd_seq;
  import inert_pkg::*;

  localparam int PWR_W = 4;
`ifdef INERT_INT_SYNC_EN
  localparam int INT_LAT = 3;
`else
  localparam int INT_LAT = 1;
`endif

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        INT     = 1'b0;
  logic        done    = 1'b1;
  logic [15:0] rd_data = 16'hEEEE;
  logic        wrt;
  logic [15:0] cmd;
  logic        cfg_done;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [31:0] exp_pair_q[$];
  logic [7:0]  byte_q[$];

  int          wrt_cnt   = 0;
  int          vld_cnt   = 0;
  int          cmpl_cnt  = 0;
  logic        spi_busy  = 1'b0;
  logic [31:0] held_pair = 32'h0;

  always #5 clk = ~clk;

  inert_rd_seq #(.PWR_W(PWR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .cfg_done  (cfg_done),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .vld       (vld),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_wrt(input int target);
    int n = 0;
    while (wrt_cnt < target && n < 1000) begin tick(); n++; end
    check("wrt_count", 64'(wrt_cnt), 64'(target));
  endtask

  task automatic wait_vld(input int target);
    int n = 0;
    while (vld_cnt < target && n < 1000) begin tick(); n++; end
    check("vld_count", 64'(vld_cnt), 64'(target));
  endtask

  task automatic wait_cmpl(input int target);
    int n = 0;
    while (cmpl_cnt < target && n < 1000) begin tick(); n++; end
    check("cmpl_count", 64'(cmpl_cnt), 64'(target));
  endtask

  task automatic push_cfg();
    for (int i = 0; i < 4; i++) exp_q.push_back(CFG_CMD[i]);
  endtask

  task automatic push_read(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(16'hA200); exp_q.push_back(16'hA300);
    exp_q.push_back(16'hAC00); exp_q.push_back(16'hAD00);
    byte_q.push_back(b0); byte_q.push_back(b1);
    byte_q.push_back(b2); byte_q.push_back(b3);
  endtask

  // SPI master model: done drops on wrt, rises 3 cycles later with the next byte.
  initial begin : spi_model
    int          cnt;
    logic [15:0] cur;
    cnt = 0;
    cur = 16'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        done     = 1'b1;
        spi_busy = 1'b0;
        cnt      = 0;
      end else if (wrt) begin
        done     = 1'b0;
        spi_busy = 1'b1;
        cnt      = 3;
        cur      = cmd;
      end else if (spi_busy) begin
        cnt--;
        if (cnt == 0) begin
          spi_busy = 1'b0;
          done     = 1'b1;
          cmpl_cnt++;
          if (cur[15] && byte_q.size() > 0) rd_data = {8'hEE, byte_q.pop_front()};
          else rd_data = 16'hEEEE;
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("reset_vals", 64'({wrt, vld, cfg_done, dbg_state, cmd, ptch_rt, AZ}), 64'(0));
        held_pair = 32'h0;
      end else begin
        if (wrt) begin
          wrt_cnt++;
          check("wrt_while_busy", 64'(spi_busy), 64'(0));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wrt: got cmd %0h, required no wrt", cmd);
          end else begin
            check("cmd", 64'(cmd), 64'(exp_q.pop_front()));
          end
        end
        if (vld) begin
          vld_cnt++;
          if (exp_pair_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld: got pair %0h, required no vld", {ptch_rt, AZ});
          end else begin
            e = exp_pair_q.pop_front();
            check("pair", 64'({ptch_rt, AZ}), 64'(e));
            held_pair = e;
          end
        end else begin
          check("pair_hold", 64'({ptch_rt, AZ}), 64'(held_pair));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   k;
    int   base;
    logic prev_cfg;

    // Power-up wait and config writes; an INT pulse during config must be ignored.
    push_cfg();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!wrt && k < 100) begin tick(); k++; end
    check("pwr_wait_cycles", 64'(k), 64'(16));
    check("cfg_done_early", 64'(cfg_done), 64'(0));
    @(negedge clk); INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    prev_cfg = cfg_done;
    k = 0;
    while (cmpl_cnt < 4 && k < 500) begin prev_cfg = cfg_done; tick(); k++; end
    check("cfg_done_before_last", 64'(prev_cfg), 64'(0));
    check("cfg_done_after_last", 64'(cfg_done), 64'(1));
    repeat (20) tick();
    check("cfg_wrt_total", 64'(wrt_cnt), 64'(4));
    check("cfg_exp_left", 64'(exp_q.size()), 64'(0));

    // Single read: INT->wrt latency, byte assembly, one-cycle vld.
    push_read(8'h34, 8'h12, 8'hCD, 8'hAB);
    exp_pair_q.push_back({16'h1234, 16'hABCD});
    base = wrt_cnt;
    @(negedge clk); INT = 1'b1;
    k = 0;
    while (wrt_cnt == base && k < 20) begin tick(); k++; end
    check("int_to_wrt", 64'(k), 64'(INT_LAT));
    @(negedge clk); INT = 1'b0;
    wait_vld(1);
    tick();
    check("vld_pulse", 64'(vld), 64'(0));
    repeat (10) tick();
    check("read1_wrt_total", 64'(wrt_cnt), 64'(8));

    // INT held across two reads: two back-to-back pairs.
    push_read(8'h78, 8'h56, 8'hF0, 8'hDE);
    push_read(8'h11, 8'h22, 8'h33, 8'h44);
    exp_pair_q.push_back({16'h5678, 16'hDEF0});
    exp_pair_q.push_back({16'h2211, 16'h4433});
    base = wrt_cnt;
    @(negedge clk); INT = 1'b1;
    wait_wrt(base + 5);
    @(negedge clk); INT = 1'b0;
    wait_vld(3);
    repeat (10) tick();
    check("exp_cmds_left", 64'(exp_q.size()), 64'(0));
    check("exp_pairs_left", 64'(exp_pair_q.size()), 64'(0));

    // Reset after the second byte of a read; INT stays high through power-up and config.
    exp_q.push_back(16'hA200); exp_q.push_back(16'hA300); exp_q.push_back(16'hAC00);
    byte_q.push_back(8'h9A); byte_q.push_back(8'hBC);
    base = cmpl_cnt;
    @(negedge clk); INT = 1'b1;
    wait_cmpl(base + 2);
    push_cfg();
    push_read(8'h01, 8'h80, 8'hFF, 8'h7F);
    exp_pair_q.push_back({16'h8001, 16'h7FFF});
    base = wrt_cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tick();
    check("restart_state", 64'(dbg_state), 64'(PWR_WAIT));
    wait_wrt(base + 5);
    @(negedge clk); INT = 1'b0;
    wait_vld(4);
    repeat (30) tick();
    check("final_cfg_done", 64'(cfg_done), 64'(1));
    check("final_cmds_left", 64'(exp_q.size()), 64'(0));
    check("final_pairs_left", 64'(exp_pair_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
